// File: rtl/hpdcache_cmo_range_seq_if.sv
// Bundle of the range-CMO request/response, source ID and dcache request signals.
// slave = the sequencer side, master = the core adapter / dcache environment side.
interface hpdcache_cmo_range_seq_if #(
  parameter int ADDR_W = 56,
  parameter int CNT_W  = 16,
  parameter int TID_W  = 6,
  parameter int SID_W  = 3
);
  logic [SID_W-1:0]  sid_i;

  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i;
  logic [CNT_W-1:0]  req_nlines_i;
  logic [1:0]        req_op_i;
  logic [TID_W-1:0]  req_tid_i;

  logic              resp_valid_o;
  logic [TID_W-1:0]  resp_tid_o;
  logic [CNT_W-1:0]  resp_issued_o;
  logic              resp_err_o;

  logic              dcache_req_valid_o;
  logic              dcache_req_ready_i;
  logic [ADDR_W-1:0] dcache_req_addr_o;
  logic [2:0]        dcache_req_size_o;
  logic [TID_W-1:0]  dcache_req_tid_o;
  logic [SID_W-1:0]  dcache_req_sid_o;

  modport slave (
    input  sid_i,
    input  req_valid_i, req_addr_i, req_nlines_i, req_op_i, req_tid_i,
    output req_ready_o,
    output resp_valid_o, resp_tid_o, resp_issued_o, resp_err_o,
    output dcache_req_valid_o, dcache_req_addr_o, dcache_req_size_o,
    output dcache_req_tid_o, dcache_req_sid_o,
    input  dcache_req_ready_i
  );

  modport master (
    output sid_i,
    output req_valid_i, req_addr_i, req_nlines_i, req_op_i, req_tid_i,
    input  req_ready_o,
    input  resp_valid_o, resp_tid_o, resp_issued_o, resp_err_o,
    input  dcache_req_valid_o, dcache_req_addr_o, dcache_req_size_o,
    input  dcache_req_tid_o, dcache_req_sid_o,
    output dcache_req_ready_i
  );
endinterface

// File: rtl/hpdcache_cmo_range_seq.sv
// Expands one range CMO into per-line dcache CMO requests; first request 1 cycle after accept, completion N+1 cycles after accept.
// Stalls on dcache_req_ready_i, completion pulse has no backpressure. Option: HPDCACHE_CMO_SEQ_INVAL_ALL_SHORTCUT_EN.
module hpdcache_cmo_range_seq #(
  parameter int ADDR_W       = 56,
  parameter int LINE_W       = 6,
  parameter int CNT_W        = 16,
  parameter int TID_W        = 6,
  parameter int SID_W        = 3,
  parameter int SHORTCUT_THR = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  hpdcache_cmo_range_seq_if.slave   io
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  localparam logic [2:0] HPDCACHE_REQ_CMO_PREFETCH    = 3'h1;
  localparam logic [2:0] HPDCACHE_REQ_CMO_INVAL_NLINE = 3'h2;
  localparam logic [2:0] HPDCACHE_REQ_CMO_INVAL_ALL   = 3'h4;

  localparam logic [1:0] OP_INVAL    = 2'b00;
  localparam logic [1:0] OP_PREFETCH = 2'b01;

`ifdef HPDCACHE_CMO_SEQ_INVAL_ALL_SHORTCUT_EN
  localparam bit SHORTCUT_EN = 1'b1;
`else
  localparam bit SHORTCUT_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LINE_INC = ADDR_W'(1) << LINE_W;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [TID_W-1:0]  tid_q, tid_d;
  logic [2:0]        size_q, size_d;
  logic              err_q, err_d;

  logic accept;
  logic op_reserved;
  logic above_thr;
  logic shortcut;
  logic line_hs;

  assign accept      = io.req_valid_i && (state_q == ST_IDLE);
  assign op_reserved = io.req_op_i[1];
  assign above_thr   = io.req_nlines_i > CNT_W'(SHORTCUT_THR);
  // A large invalidate collapses into a single whole-cache invalidate.
  assign shortcut    = SHORTCUT_EN && (io.req_op_i == OP_INVAL) && above_thr;
  assign line_hs     = (state_q == ST_ISSUE) && io.dcache_req_ready_i;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    issued_d    = issued_q;
    tid_d       = tid_q;
    size_d      = size_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tid_d    = io.req_tid_i;
          issued_d = '0;
          err_d    = op_reserved;
          if (shortcut) begin
            cur_addr_d  = '0;
            remaining_d = CNT_W'(1);
            size_d      = HPDCACHE_REQ_CMO_INVAL_ALL;
          end else begin
            cur_addr_d  = {io.req_addr_i[ADDR_W-1:LINE_W], {LINE_W{1'b0}}};
            remaining_d = io.req_nlines_i;
            size_d      = (io.req_op_i == OP_PREFETCH) ? HPDCACHE_REQ_CMO_PREFETCH
                                                       : HPDCACHE_REQ_CMO_INVAL_NLINE;
          end
          if (op_reserved || (io.req_nlines_i == '0)) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        if (line_hs) begin
          // Address wraps silently at the top of the physical space.
          cur_addr_d  = cur_addr_q + LINE_INC;
          remaining_d = remaining_q - CNT_W'(1);
          issued_d    = issued_q + CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = ST_ACK;
          end
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      issued_q    <= '0;
      tid_q       <= '0;
      size_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      issued_q    <= issued_d;
      tid_q       <= tid_d;
      size_q      <= size_d;
      err_q       <= err_d;
    end
  end

  assign io.req_ready_o = (state_q == ST_IDLE);

  assign io.resp_valid_o  = (state_q == ST_ACK);
  assign io.resp_tid_o    = tid_q;
  assign io.resp_issued_o = issued_q;
  assign io.resp_err_o    = (state_q == ST_ACK) && err_q;

  assign io.dcache_req_valid_o = (state_q == ST_ISSUE);
  assign io.dcache_req_addr_o  = cur_addr_q;
  assign io.dcache_req_size_o  = size_q;
  assign io.dcache_req_tid_o   = tid_q;
  assign io.dcache_req_sid_o   = io.sid_i;

endmodule

// File: tb/tb_hpdcache_cmo_range_seq.sv
// Scoreboard bench for hpdcache_cmo_range_seq: directed cases then randomized ranges under random dcache backpressure.
module tb_hpdcache_cmo_range_seq;
  localparam int ADDR_W = 56;
  localparam int LINE_W = 6;
  localparam int CNT_W  = 16;
  localparam int TID_W  = 6;
  localparam int SID_W  = 3;
  localparam int THR    = 64;

`ifdef HPDCACHE_CMO_SEQ_INVAL_ALL_SHORTCUT_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  localparam logic [2:0] SZ_PREFETCH = 3'h1;
  localparam logic [2:0] SZ_INVAL_NL = 3'h2;
  localparam logic [2:0] SZ_INVAL_AL = 3'h4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
    logic [TID_W-1:0]  tid;
    bit                first;
    int                acc;
  } dreq_t;

  typedef struct {
    logic [TID_W-1:0] tid;
    logic [CNT_W-1:0] issued;
    logic             err;
    int               nissue;
    int               acc;
    int               due;
  } dresp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [SID_W-1:0] sid = 3'h5;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int rmode = 0;
  int stall_budget = 0;
  int stall_used = 0;
  int hs_count = 0;
  int last_hs = 0;
  int resp_count = 0;
  bit front_seen = 1'b0;
  dreq_t  exp_req[$];
  dresp_t exp_resp[$];
  dreq_t  e;
  dresp_t r;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hpdcache_cmo_range_seq_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TID_W(TID_W), .SID_W(SID_W)) bus ();

  hpdcache_cmo_range_seq #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W),
    .TID_W(TID_W), .SID_W(SID_W), .SHORTCUT_THR(THR)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .io     (bus)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference model: the line list a range CMO should produce.
  task automatic send(input logic [ADDR_W-1:0] addr, input int n, input logic [1:0] op,
                      input logic [TID_W-1:0] tid);
    int w;
    int nissue;
    logic [ADDR_W-1:0] base;
    logic [63:0] t;
    dreq_t  q;
    dresp_t rs;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready_o && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) fail_now("accept_timeout");
    base = {addr[ADDR_W-1:LINE_W], {LINE_W{1'b0}}};
    nissue = 0;
    if (op[1]) begin
      nissue = 0;
    end else if (SC && op == 2'b00 && n > THR) begin
      q.addr = '0; q.size = SZ_INVAL_AL; q.tid = tid; q.first = 1'b1; q.acc = cyc;
      exp_req.push_back(q);
      nissue = 1;
    end else begin
      for (int i = 0; i < n; i++) begin
        t = {8'h0, base} + (64'(i) << LINE_W);
        q.addr = t[ADDR_W-1:0];
        q.size = (op == 2'b01) ? SZ_PREFETCH : SZ_INVAL_NL;
        q.tid = tid; q.first = (i == 0); q.acc = cyc;
        exp_req.push_back(q);
      end
      nissue = n;
    end
    rs.tid = tid; rs.issued = CNT_W'(nissue); rs.err = op[1];
    rs.nissue = nissue; rs.acc = cyc;
    rs.due = (rmode == 0 && stall_budget == stall_used) ? cyc + nissue + 1 : -1;
    exp_resp.push_back(rs);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i = addr;
    bus.req_nlines_i = CNT_W'(n);
    bus.req_op_i = op;
    bus.req_tid_i = tid;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_addr_i = ADDR_W'({$urandom(), $urandom()});
    bus.req_nlines_i = CNT_W'($urandom());
    bus.req_op_i = 2'($urandom());
    bus.req_tid_i = TID_W'($urandom());
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_resp.size() != 0 || exp_req.size() != 0) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) fail_now("drain_timeout");
  endtask

  // dcache backpressure source.
  initial begin
    bus.dcache_req_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_used < stall_budget && bus.dcache_req_valid_o) begin
        bus.dcache_req_ready_i = 1'b0;
        stall_used++;
      end else if (rmode == 0) begin
        bus.dcache_req_ready_i = 1'b1;
      end else begin
        bus.dcache_req_ready_i = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: compares every presented dcache request and completion against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      front_seen = 1'b0;
    end else begin
      if (bus.dcache_req_valid_o) begin
        if (exp_req.size() == 0) begin
          fail_now("unexpected_dcache_req");
        end else begin
          e = exp_req[0];
          if (e.first && !front_seen) chk("first_req_latency", 64'(cyc), 64'(e.acc + 1));
          front_seen = 1'b1;
          chk("dreq_addr", 64'(bus.dcache_req_addr_o), 64'(e.addr));
          chk("dreq_size", 64'(bus.dcache_req_size_o), 64'(e.size));
          chk("dreq_tid", 64'(bus.dcache_req_tid_o), 64'(e.tid));
          chk("dreq_sid", 64'(bus.dcache_req_sid_o), 64'(sid));
          if (bus.dcache_req_ready_i) begin
            void'(exp_req.pop_front());
            front_seen = 1'b0;
            last_hs = cyc;
            hs_count++;
          end
        end
      end
      if (bus.resp_valid_o) begin
        resp_count++;
        if (exp_resp.size() == 0) begin
          fail_now("unexpected_resp");
        end else begin
          r = exp_resp.pop_front();
          chk("resp_tid", 64'(bus.resp_tid_o), 64'(r.tid));
          chk("resp_issued", 64'(bus.resp_issued_o), 64'(r.issued));
          chk("resp_err", 64'(bus.resp_err_o), 64'(r.err));
          chk("lines_left_at_resp", 64'(exp_req.size()), 64'd0);
          if (r.nissue == 0) chk("resp_latency", 64'(cyc), 64'(r.acc + 1));
          else chk("resp_latency", 64'(cyc), 64'(last_hs + 1));
          if (r.due >= 0) chk("resp_due", 64'(cyc), 64'(r.due));
        end
      end
    end
  end

  initial begin
    int h0;
    int rc0;
    int w;
    logic [ADDR_W-1:0] a;
    int n;
    int k;
    logic [1:0] op;
    bus.sid_i = sid;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i = '0;
    bus.req_nlines_i = '0;
    bus.req_op_i = '0;
    bus.req_tid_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("rst_resp_err", 64'(bus.resp_err_o), 64'd0);
    chk("rst_resp_issued", 64'(bus.resp_issued_o), 64'd0);
    chk("rst_resp_tid", 64'(bus.resp_tid_o), 64'd0);
    chk("rst_dreq_valid", 64'(bus.dcache_req_valid_o), 64'd0);
    chk("rst_dreq_addr", 64'(bus.dcache_req_addr_o), 64'd0);
    chk("rst_dreq_tid", 64'(bus.dcache_req_tid_o), 64'd0);
    rst_n = 1'b1;

    rmode = 0;
    send(56'h1007, 3, 2'b00, 6'h2a);
    drain();

    stall_budget = stall_used + 3;
    send(56'h20_0040, 2, 2'b01, 6'h11);
    drain();
    chk("stall_cycles_used", 64'(stall_used), 64'(stall_budget));

    send(56'h3000, 0, 2'b00, 6'h07);
    send(56'h3000, 5, 2'b10, 6'h08);
    send(56'h3040, 1, 2'b11, 6'h09);
    drain();

    send({ADDR_W{1'b1}} - 56'd63, 2, 2'b01, 6'h0a);
    drain();

    // Reset in the middle of a 5-line invalidate.
    h0 = hs_count;
    send(56'h4000, 5, 2'b00, 6'h0b);
    w = 0;
    while (hs_count == h0 && w < 100) begin
      @(posedge clk);
      #2;
      w++;
    end
    if (w >= 100) fail_now("midop_handshake_timeout");
    rst_n = 1'b0;
    #1;
    chk("midop_rst_dreq_valid", 64'(bus.dcache_req_valid_o), 64'd0);
    chk("midop_rst_req_ready", 64'(bus.req_ready_o), 64'd1);
    exp_req.delete();
    exp_resp.delete();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    rc0 = resp_count;
    repeat (10) @(negedge clk);
    chk("no_resp_after_reset", 64'(resp_count), 64'(rc0));
    send(56'h5010, 4, 2'b00, 6'h0c);
    drain();

    send(56'h8000, 65, 2'b00, 6'h0d);
    drain();
    send(56'h9000, 64, 2'b00, 6'h0e);
    drain();
    send(56'ha000, 65, 2'b01, 6'h0f);
    drain();

    rmode = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) a = {ADDR_W{1'b1}} - ADDR_W'($urandom_range(0, 1023));
      else a = ADDR_W'({$urandom(), $urandom()});
      n = $urandom_range(0, 70);
      k = $urandom_range(0, 9);
      op = (k < 4) ? 2'b00 : (k < 8) ? 2'b01 : (k == 8) ? 2'b10 : 2'b11;
      send(a, n, op, TID_W'($urandom()));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
